multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM that sequences the RV32I datapath (pc, instruction register, register_file, alu, sign_extend) as a multi-cycle machine sharing one memory port for fetch and data.
- Decodes the latched instruction and drives the datapath enables, ALU op, mux selects and the memory request handshake.
- Halts on illegal instructions or a memory timeout.
- Exposes a retired-instruction counter for bench checking.

Parameters:
- TIMEOUT_CYCLES, 16: maximum consecutive cycles mem_req may wait for mem_ready before trapping; legal range 1..255.
- COUNT_W, 32: width of retired_count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  instruction-register contents (valid from DECODE onward).
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request; held high until mem_ready is sampled high.
- mem_we  output  1  write request; only meaningful while mem_req is high.
- ir_write  output  1  latch fetched word into the instruction register.
- pc_write  output  1  load pc with pc+4.
- reg_write  output  1  register_file write_enable.
- alu_op  output  3  alu_op_t code.
- alu_src_imm  output  1  ALU operand b from sign_extend when 1, else rs2.
- wb_sel_mem  output  1  writeback data comes from memory when 1, else from the ALU.
- halted  output  1  FSM is in TRAP.
- trap_cause  output  2  0 none, 1 illegal, 2 timeout.
- retired_count  output  COUNT_W  instructions completed since reset.

Behaviour:
- Reset:
  - While reset is high, every strobe (mem_req, mem_we, ir_write, pc_write, reg_write) is forced to 0.
  - The next edge sets state FETCH, trap_cause 0, retired_count 0, wait counter 0.
  - Reset wins at any state, including mid-MEM. No pc_write or reg_write occurs on the reset cycle.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. Outputs are Moore-decoded from state and the decoded instruction; ir_write and pc_write additionally depend on mem_ready.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready=1: ir_write=1 for that cycle, then go to DECODE.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT_CYCLES-1 with mem_ready still low, go to TRAP with cause 2.
- DECODE:
  - Classify the instruction as R-ALU (0110011), I-ALU (0010011), LW (0000011, funct3 010) or SW (0100011, funct3 010).
  - Anything else goes to TRAP with cause 1. Instruction 0x00000000 is illegal.
- alu_op mapping from funct3:
  - 000: ADD; SUB only for R-type with funct7=0100000.
  - 001: SLL.
  - 010: SLT.
  - 100: XOR.
  - 101: SRL.
  - 110: OR.
  - 111: AND.
- Illegal ALU encodings:
  - funct3 011.
  - R-type funct7 other than 0000000, or 0100000 with funct3 000.
  - SLLI/SRLI with imm[11:5] not equal to 0.
  - All of these trap with cause 1.
- EXECUTE:
  - ALU computes.
  - alu_src_imm=1 for I-ALU, LW and SW; 0 for R-ALU.
  - LW/SW use alu_op ADD.
  - Next state is MEM for LW/SW, else WRITEBACK.
- MEM:
  - mem_req=1; mem_we=1 for SW only. Same wait and timeout rules as FETCH.
  - On mem_ready, SW retires (pc_write=1, retired_count+1, go to FETCH) and LW goes to WRITEBACK.
- WRITEBACK:
  - reg_write=1 and pc_write=1 for one cycle.
  - wb_sel_mem=1 for LW.
  - retired_count+1, then go to FETCH.
- Wait counter: 8 bits, cleared on every state entry.
- Latency with zero-wait memory: R/I-ALU 4 cycles, LW 5, SW 4.
- Handshake rules:
  - mem_req never drops before ready is sampled.
  - mem_we is stable for the whole request.
  - mem_ready while mem_req=0 is ignored.
- TRAP: all strobes 0, halted=1, trap_cause held; remain until reset.
- retired_count wraps modulo 2^COUNT_W.

Decomposition:
- Package cpu_pkg holds:
  - alu_op_t (moved here and shared with alu).
  - Opcode constants OP_RALU, OP_IALU, OP_LOAD, OP_STORE.
  - ctrl_state_t.
  - trap_cause_t.
- Sub-module instr_decoder is combinational: instr in; outputs instr class, alu_op and illegal flag.

Test Plan:
- add x7,x6,x5 (0x005303b3), mem_ready tied 1 → ir_write in cycle 1, alu_op=ADD and alu_src_imm=0 in EXECUTE, reg_write=pc_write=1 in cycle 4, retired_count=1.
- sub x7,x6,x5 (0x405303b3) → alu_op=SUB in EXECUTE; 4-cycle retire.
- lw x1,4(x2) (0x00412083), mem_ready low 3 cycles in MEM → mem_req held 4 cycles with mem_we=0, then WRITEBACK with wb_sel_mem=1 and reg_write=1; 8 cycles total.
- sw x1,8(x2) (0x00112423) → mem_req=mem_we=1 in MEM, pc_write in MEM cycle, reg_write never asserted.
- instr=0x00000000 → TRAP after DECODE, halted=1, trap_cause=1, no further strobes for 20 cycles.
- mem_ready held 0 in FETCH with TIMEOUT_CYCLES=16 → TRAP with cause 2 after exactly 16 request cycles.
- Reset asserted mid-MEM of sw → mem_req=0 during reset, FETCH and retired_count=0 after.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller and its datapath.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLL = 3'd2,
        ALU_SLT = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SRL = 3'd5,
        ALU_OR  = 3'd6,
        ALU_AND = 3'd7
    } alu_op_t;

    localparam logic [6:0] OP_RALU  = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_WORD  = 3'b010;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_TIMEOUT = 2'd2
    } trap_cause_t;

    typedef enum logic [1:0] {
        CLS_RALU  = 2'd0,
        CLS_IALU  = 2'd1,
        CLS_LOAD  = 2'd2,
        CLS_STORE = 2'd3
    } instr_class_t;

    // funct3 3'b011 has no ALU meaning here; callers flag it as illegal.
    function automatic alu_op_t f3_to_alu_op(input logic [2:0] funct3);
        case (funct3)
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Single shared memory port used for both instruction fetch and load/store traffic.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/instr_decoder.sv
// Combinational classifier for the supported RV32I subset: R-ALU, I-ALU, LW and SW.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t instr_class,
    output alu_op_t      alu_op,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        instr_class = CLS_RALU;
        alu_op      = f3_to_alu_op(funct3);
        illegal     = 1'b0;
        case (opcode)
            OP_RALU: begin
                instr_class = CLS_RALU;
                if (funct3 == 3'b011) begin
                    illegal = 1'b1;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    alu_op = ALU_SUB;
                end else if (funct7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
            end
            OP_IALU: begin
                instr_class = CLS_IALU;
                // Shift-immediates only accept a zero upper field; SRAI is not supported.
                if (funct3 == 3'b011) begin
                    illegal = 1'b1;
                end else if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                instr_class = CLS_LOAD;
                alu_op      = ALU_ADD;
                illegal     = (funct3 != F3_WORD);
            end
            OP_STORE: begin
                instr_class = CLS_STORE;
                alu_op      = ALU_ADD;
                illegal     = (funct3 != F3_WORD);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback over one memory port
// and halts on illegal instructions or memory timeouts.
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int COUNT_W        = 32
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  instr,
    multicycle_controller_if.master      bus,
    output logic                         ir_write,
    output logic                         pc_write,
    output logic                         reg_write,
    output alu_op_t                      alu_op,
    output logic                         alu_src_imm,
    output logic                         wb_sel_mem,
    output logic                         halted,
    output trap_cause_t                  trap_cause,
    output logic [COUNT_W-1:0]           retired_count
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    ctrl_state_t          state;
    trap_cause_t          trap_cause_q;
    logic [COUNT_W-1:0]   retired_q;
    logic [7:0]           wait_cnt;
    instr_class_t         cls_q;
    alu_op_t              op_q;

    instr_class_t         dec_class;
    alu_op_t              dec_op;
    logic                 dec_illegal;

    instr_decoder u_decoder (
        .instr       (instr),
        .instr_class (dec_class),
        .alu_op      (dec_op),
        .illegal     (dec_illegal)
    );

    // wait_cnt defaults to zero so every state change clears it; only a stalled request counts up.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FETCH;
            trap_cause_q <= TRAP_NONE;
            retired_q    <= '0;
            wait_cnt     <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= S_TRAP;
                        trap_cause_q <= TRAP_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    cls_q <= dec_class;
                    op_q  <= dec_op;
                    if (dec_illegal) begin
                        state        <= S_TRAP;
                        trap_cause_q <= TRAP_ILLEGAL;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    state <= (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? S_MEM : S_WRITEBACK;
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (cls_q == CLS_STORE) begin
                            retired_q <= retired_q + COUNT_W'(1);
                            state     <= S_FETCH;
                        end else begin
                            state <= S_WRITEBACK;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= S_TRAP;
                        trap_cause_q <= TRAP_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WRITEBACK: begin
                    retired_q <= retired_q + COUNT_W'(1);
                    state     <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes are gated by reset so nothing leaks out while the FSM is being re-initialised.
    always_comb begin
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        wb_sel_mem  = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req = ~reset;
                ir_write    = ~reset & bus.mem_ready;
            end
            S_EXECUTE: begin
                alu_op      = op_q;
                alu_src_imm = (cls_q != CLS_RALU);
            end
            S_MEM: begin
                alu_op      = op_q;
                alu_src_imm = 1'b1;
                bus.mem_req = ~reset;
                bus.mem_we  = ~reset & (cls_q == CLS_STORE);
                pc_write    = ~reset & bus.mem_ready & (cls_q == CLS_STORE);
            end
            S_WRITEBACK: begin
                alu_op      = op_q;
                alu_src_imm = (cls_q != CLS_RALU);
                wb_sel_mem  = (cls_q == CLS_LOAD);
                reg_write   = ~reset;
                pc_write    = ~reset;
            end
            default: begin
            end
        endcase
    end

    assign halted        = (state == S_TRAP);
    assign trap_cause    = trap_cause_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: randomized instruction streams and memory latencies against a
// latency/legality reference model derived from the instruction-set rules.
module tb_multicycle_controller;
    import cpu_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CW      = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          ir_write, pc_write, reg_write, alu_src_imm, wb_sel_mem, halted;
    alu_op_t       alu_op;
    trap_cause_t   trap_cause;
    logic [CW-1:0] retired_count;

    multicycle_controller_if bus();

    multicycle_controller #(.TIMEOUT_CYCLES(TIMEOUT), .COUNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .bus           (bus),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_op        (alu_op),
        .alu_src_imm   (alu_src_imm),
        .wb_sel_mem    (wb_sel_mem),
        .halted        (halted),
        .trap_cause    (trap_cause),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_retired = 0;

    // Reference: legality, class (0 R, 1 I, 2 LW, 3 SW), ALU op and immediate select from ISA fields.
    function automatic void model(input logic [31:0] w, output bit legal, output int cls,
                                  output alu_op_t op, output bit imm);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        legal = 1'b0; cls = -1; imm = 1'b1;
        case (f3)
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd4: op = ALU_XOR;
            3'd5: op = ALU_SRL;
            3'd6: op = ALU_OR;
            3'd7: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        if (opc == 7'h33) begin
            cls = 0; imm = 1'b0;
            if (f7 == 7'h00) legal = (f3 != 3'd3);
            else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1'b1; op = ALU_SUB; end
        end else if (opc == 7'h13) begin
            cls = 1;
            legal = (f3 != 3'd3) && !((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00);
        end else if (opc == 7'h03) begin
            cls = 2; op = ALU_ADD; legal = (f3 == 3'd2);
        end else if (opc == 7'h23) begin
            cls = 3; op = ALU_ADD; legal = (f3 == 3'd2);
        end
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        logic [31:0] w;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = 12'($urandom);
        f3 = 3'($urandom);
        if (f3 == 3'd3) f3 = 3'd0;
        case ($urandom_range(0, 3))
            0: begin
                f7 = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                w = {f7, rs2, rs1, f3, rd, 7'h33};
            end
            1: begin
                if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = 7'h00;
                w = {imm, rs1, f3, rd, 7'h13};
            end
            2: w = {imm, rs1, 3'b010, rd, 7'h03};
            default: w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
        endcase
        return w;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 00000", {bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        exp_retired = 0;
    endtask

    // Runs one instruction from its first FETCH cycle; wf/wm are wait cycles before mem_ready.
    task automatic run_one(input logic [31:0] ins, input int wf, input int wm);
        bit legal, imm_exp, imm_seen, done;
        int cls, cyc, run, ir_cyc, pc_cyc, rw_cyc, halt_cyc, rw_n, req_n, we_bad, wbsel_n, quiet_bad;
        int exp_len, exp_req;
        alu_op_t op_exp, op_seen;
        model(ins, legal, cls, op_exp, imm_exp);
        cyc = 0; run = 0; ir_cyc = 0; pc_cyc = 0; rw_cyc = 0; halt_cyc = 0;
        rw_n = 0; req_n = 0; we_bad = 0; wbsel_n = 0; quiet_bad = 0;
        done = 1'b0; op_seen = ALU_ADD; imm_seen = 1'b0;
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) instr = ins;
            if (bus.mem_req) begin
                bus.mem_ready = (run == ((ir_cyc == 0) ? wf : wm));
                run = bus.mem_ready ? 0 : run + 1;
            end else begin
                bus.mem_ready = ($urandom_range(0, 2) == 0);
            end
            #1;
            if (bus.mem_req) req_n++;
            if (bus.mem_req && (bus.mem_we !== (ir_cyc != 0 && cls == 3))) we_bad++;
            if (ir_write) ir_cyc = cyc;
            if (ir_cyc != 0 && cyc == ir_cyc + 2) begin op_seen = alu_op; imm_seen = alu_src_imm; end
            if (reg_write) begin rw_n++; rw_cyc = cyc; if (wb_sel_mem) wbsel_n++; end
            if (pc_write) begin pc_cyc = cyc; done = 1'b1; end
            if (halted) begin halt_cyc = cyc; done = 1'b1; end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL finish ins=%h no retire or trap within %0d cycles", ins, cyc); end
        checks++;
        if (ir_cyc !== wf + 1) begin errors++; $display("FAIL ir_write_cycle ins=%h got %0d exp %0d", ins, ir_cyc, wf + 1); end
        if (legal) begin
            exp_len = (cls <= 1) ? wf + 4 : ((cls == 2) ? wf + wm + 5 : wf + wm + 4);
            exp_req = (cls <= 1) ? wf + 1 : wf + wm + 2;
            checks++;
            if (pc_cyc !== exp_len) begin errors++; $display("FAIL retire_cycle ins=%h got %0d exp %0d", ins, pc_cyc, exp_len); end
            checks++;
            if (req_n !== exp_req) begin errors++; $display("FAIL req_cycles ins=%h got %0d exp %0d", ins, req_n, exp_req); end
            checks++;
            if (we_bad !== 0) begin errors++; $display("FAIL mem_we ins=%h bad cycles %0d exp 0", ins, we_bad); end
            checks++;
            if (op_seen !== op_exp) begin errors++; $display("FAIL alu_op ins=%h got %0d exp %0d", ins, op_seen, op_exp); end
            checks++;
            if (imm_seen !== imm_exp) begin errors++; $display("FAIL alu_src_imm ins=%h got %0d exp %0d", ins, imm_seen, imm_exp); end
            checks++;
            if (rw_n !== ((cls == 3) ? 0 : 1) || rw_cyc !== ((cls == 3) ? 0 : exp_len)) begin
                errors++; $display("FAIL reg_write ins=%h got count %0d at %0d exp count %0d", ins, rw_n, rw_cyc, (cls == 3) ? 0 : 1);
            end
            checks++;
            if (wbsel_n !== ((cls == 2) ? 1 : 0)) begin errors++; $display("FAIL wb_sel_mem ins=%h got %0d exp %0d", ins, wbsel_n, (cls == 2) ? 1 : 0); end
            checks++;
            if (halt_cyc !== 0) begin errors++; $display("FAIL halted ins=%h got halt at %0d exp none", ins, halt_cyc); end
            @(posedge clk);
            #1;
            exp_retired = (exp_retired + 1) % (1 << CW);
            checks++;
            if (retired_count !== CW'(exp_retired)) begin errors++; $display("FAIL retired_count ins=%h got %0d exp %0d", ins, retired_count, exp_retired); end
        end else begin
            checks++;
            if (halt_cyc !== wf + 3) begin errors++; $display("FAIL trap_cycle ins=%h got %0d exp %0d", ins, halt_cyc, wf + 3); end
            checks++;
            if (trap_cause !== 2'd1) begin errors++; $display("FAIL trap_cause ins=%h got %0d exp 1", ins, trap_cause); end
            checks++;
            if (pc_cyc !== 0 || rw_n !== 0) begin errors++; $display("FAIL illegal_writes ins=%h got pc %0d reg %0d exp 0 0", ins, pc_cyc, rw_n); end
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                bus.mem_ready = 1'($urandom_range(0, 1));
                #1;
                if (bus.mem_req || bus.mem_we || ir_write || pc_write || reg_write || !halted) quiet_bad++;
            end
            checks++;
            if (quiet_bad !== 0 || trap_cause !== 2'd1) begin
                errors++; $display("FAIL trap_hold ins=%h got bad %0d cause %0d exp 0 1", ins, quiet_bad, trap_cause);
            end
            checks++;
            if (retired_count !== CW'(exp_retired)) begin errors++; $display("FAIL trap_retired ins=%h got %0d exp %0d", ins, retired_count, exp_retired); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        instr = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write} !== 5'b0) begin
            errors++; $display("FAIL init_reset_strobes got %b exp 00000", {bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        exp_retired = 0;
        #1;
        checks++;
        if (retired_count !== '0 || trap_cause !== 2'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL post_reset got count %0d cause %0d halted %0d exp 0 0 0", retired_count, trap_cause, halted);
        end
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL post_reset_fetch got req %0d we %0d exp 1 0", bus.mem_req, bus.mem_we);
        end
    endtask

    task automatic test_directed();
        run_one(32'h005303b3, 0, 0);
        run_one(32'h405303b3, 0, 0);
        run_one(32'h00412083, 0, 3);
        run_one(32'h00112423, 0, 0);
        run_one(32'h00500093, 1, 0);
        run_one(32'h00309093, 0, 0);
        run_one(32'h0052d3b3, 2, 0);
        run_one(32'h005303b3, TIMEOUT - 1, 0);
        run_one(32'h00412083, 0, TIMEOUT - 1);
        run_one(32'h00112423, 1, TIMEOUT - 1);
    endtask

    task automatic test_illegal();
        logic [31:0] bad [8];
        bad[0] = 32'h0;
        bad[1] = {7'h00, 5'd5, 5'd6, 3'b011, 5'd7, 7'h33};
        bad[2] = {7'h20, 5'd5, 5'd6, 3'b100, 5'd7, 7'h33};
        bad[3] = {7'h01, 5'd5, 5'd6, 3'b000, 5'd7, 7'h33};
        bad[4] = {7'h20, 5'd3, 5'd6, 3'b101, 5'd7, 7'h13};
        bad[5] = {12'd4, 5'd2, 3'b000, 5'd1, 7'h03};
        bad[6] = {7'h00, 5'd1, 5'd2, 3'b001, 5'd8, 7'h23};
        bad[7] = 32'h0000006f;
        for (int i = 0; i < 8; i++) begin
            apply_reset();
            run_one(bad[i], i % 3, 0);
        end
    endtask

    task automatic test_timeout();
        int req, hc;
        apply_reset();
        instr = 32'h005303b3;
        req = 0; hc = 0;
        for (int c = 1; c <= 40 && hc == 0; c++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            if (bus.mem_req) req++;
            if (halted) hc = c;
        end
        checks++;
        if (req !== TIMEOUT || hc !== TIMEOUT + 1) begin
            errors++; $display("FAIL fetch_timeout got req %0d halt %0d exp %0d %0d", req, hc, TIMEOUT, TIMEOUT + 1);
        end
        checks++;
        if (trap_cause !== 2'd2) begin errors++; $display("FAIL fetch_timeout_cause got %0d exp 2", trap_cause); end

        apply_reset();
        instr = 32'h00412083;
        req = 0; hc = 0;
        for (int c = 1; c <= 50 && hc == 0; c++) begin
            @(negedge clk);
            bus.mem_ready = (c == 1);
            #1;
            if (bus.mem_req) req++;
            if (halted) hc = c;
        end
        checks++;
        if (req !== TIMEOUT + 1 || hc !== TIMEOUT + 4) begin
            errors++; $display("FAIL mem_timeout got req %0d halt %0d exp %0d %0d", req, hc, TIMEOUT + 1, TIMEOUT + 4);
        end
        checks++;
        if (trap_cause !== 2'd2 || retired_count !== '0) begin
            errors++; $display("FAIL mem_timeout_state got cause %0d count %0d exp 2 0", trap_cause, retired_count);
        end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        run_one(32'h005303b3, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) instr = 32'h00112423;
            bus.mem_ready = (c == 1);
            #1;
        end
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            errors++; $display("FAIL sw_mem_phase got req %0d we %0d exp 1 1", bus.mem_req, bus.mem_we);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, pc_write, reg_write} !== 4'b0) begin
            errors++; $display("FAIL mid_mem_reset_strobes got %b exp 0000", {bus.mem_req, bus.mem_we, pc_write, reg_write});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        exp_retired = 0;
        #1;
        checks++;
        if (retired_count !== '0 || halted !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL mid_mem_after got count %0d halted %0d req %0d we %0d exp 0 0 1 0",
                               retired_count, halted, bus.mem_req, bus.mem_we);
        end
    endtask

    task automatic test_random_words();
        logic [31:0] w;
        for (int i = 0; i < 40; i++) begin
            apply_reset();
            w = rand_legal();
            if ($urandom_range(0, 1) == 1) w = w ^ (32'h1 << $urandom_range(0, 31));
            run_one(w, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        int wf, wm;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            wf = ($urandom_range(0, 19) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 19) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            run_one(rand_legal(), wf, wm);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_random_words();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
